// File: rtl/clb_bitstream_programmer_if.sv
// Frame handshake between the configuration host (master) and clb_bitstream_programmer (slave).
interface clb_bitstream_programmer_if #(
  parameter int FRAME_W = 37
);
  logic [FRAME_W-1:0] frame_data;
  logic               frame_valid;
  logic               frame_ready;

  modport master (output frame_data, output frame_valid, input frame_ready);
  modport slave  (input frame_data, input frame_valid, output frame_ready);
endinterface

// File: rtl/clb_bitstream_programmer.sv
// Serialises one FRAME_W-bit frame per CLB, LSB first, with clb_prgm_b as the loader shift enable.
// Optional macro CFG_CHAIN_CHECK_EN: wait (with timeout) for clb_chain_done before releasing prgm_b.
module clb_bitstream_programmer #(
  parameter int NUM_CLB     = 4,
  parameter int FRAME_W     = 37,
  parameter int CHK_TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  clb_bitstream_programmer_if.slave frame,
  output logic                     bit_out,
  output logic                     prgm_b,
  output logic                     clb_prgm_b,
  output logic                     clb_chain_in,
  input  logic                     clb_chain_done,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  localparam int FCW = $clog2(NUM_CLB + 1);
  localparam int BCW = $clog2(FRAME_W);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    LOAD,
    SHIFT,
`ifdef CFG_CHAIN_CHECK_EN
    CHECK,
`endif
    FINISH
  } state_t;

  state_t             state, state_d;
  logic [FCW-1:0]     frame_cnt, frame_cnt_d;
  logic [BCW-1:0]     bit_cnt, bit_cnt_d;
  logic [FRAME_W-2:0] shreg, shreg_d;
  logic               bit_out_d, prgm_b_d, clb_prgm_b_d, chain_in_d;
  logic               ready_d, busy_d, done_d;

`ifdef CFG_CHAIN_CHECK_EN
  localparam int CKW = $clog2(CHK_TIMEOUT + 1);
  logic [CKW-1:0] chk_cnt, chk_cnt_d;
  logic           error_d;
`else
  logic [31:0] unused_cfg;
  assign unused_cfg = {31'(CHK_TIMEOUT), clb_chain_done};
  assign error      = 1'b0;
`endif

  always_comb begin
    // NOTE: every next-value gets its hold value first, so no branch can infer a latch.
    state_d      = state;
    frame_cnt_d  = frame_cnt;
    bit_cnt_d    = bit_cnt;
    shreg_d      = shreg;
    bit_out_d    = bit_out;
    prgm_b_d     = prgm_b;
    clb_prgm_b_d = clb_prgm_b;
    chain_in_d   = clb_chain_in;
    ready_d      = frame.frame_ready;
    busy_d       = busy;
    done_d       = 1'b0;
`ifdef CFG_CHAIN_CHECK_EN
    chk_cnt_d    = chk_cnt;
    error_d      = error;
`endif

    unique case (state)
      IDLE: begin
        if (start) begin
          state_d     = ARM;
          busy_d      = 1'b1;
          prgm_b_d    = 1'b0;
          chain_in_d  = 1'b1;
          frame_cnt_d = '0;
`ifdef CFG_CHAIN_CHECK_EN
          error_d     = 1'b0;
`endif
        end
      end
      ARM: begin
        state_d = LOAD;
        ready_d = 1'b1;
      end
      LOAD: begin
        // Loaders hold while clb_prgm_b is low, so an idle host simply stretches this state.
        if (frame.frame_valid && frame.frame_ready) begin
          shreg_d      = frame.frame_data[FRAME_W-1:1];
          bit_out_d    = frame.frame_data[0];
          clb_prgm_b_d = 1'b1;
          ready_d      = 1'b0;
          bit_cnt_d    = '0;
          state_d      = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_cnt == BCW'(FRAME_W - 1)) begin
          clb_prgm_b_d = 1'b0;
          frame_cnt_d  = frame_cnt + 1'b1;
          if (frame_cnt_d == FCW'(NUM_CLB)) begin
`ifdef CFG_CHAIN_CHECK_EN
            state_d    = CHECK;
            chk_cnt_d  = '0;
`else
            state_d    = FINISH;
            prgm_b_d   = 1'b1;
            chain_in_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
`endif
          end else begin
            state_d = LOAD;
            ready_d = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt + 1'b1;
          bit_out_d = shreg[0];
          shreg_d   = shreg >> 1;
        end
      end
`ifdef CFG_CHAIN_CHECK_EN
      CHECK: begin
        chk_cnt_d = chk_cnt + 1'b1;
        if (clb_chain_done || chk_cnt == CKW'(CHK_TIMEOUT - 1)) begin
          state_d    = FINISH;
          prgm_b_d   = 1'b1;
          chain_in_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          error_d    = !clb_chain_done;
        end
      end
`endif
      // done is already high for this one cycle; the default drops it on exit.
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      frame_cnt         <= '0;
      bit_cnt           <= '0;
      bit_out           <= 1'b0;
      prgm_b            <= 1'b1;
      clb_prgm_b        <= 1'b0;
      clb_chain_in      <= 1'b0;
      frame.frame_ready <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
`ifdef CFG_CHAIN_CHECK_EN
      chk_cnt           <= '0;
      error             <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking updates so every register samples the same pre-edge values.
      state             <= state_d;
      frame_cnt         <= frame_cnt_d;
      bit_cnt           <= bit_cnt_d;
      bit_out           <= bit_out_d;
      prgm_b            <= prgm_b_d;
      clb_prgm_b        <= clb_prgm_b_d;
      clb_chain_in      <= chain_in_d;
      frame.frame_ready <= ready_d;
      busy              <= busy_d;
      done              <= done_d;
`ifdef CFG_CHAIN_CHECK_EN
      chk_cnt           <= chk_cnt_d;
      error             <= error_d;
`endif
    end
  end

  // NOTE: the shift register is datapath only; it is always loaded in LOAD before it is read, so it has no reset.
  always_ff @(posedge clk) begin
    shreg <= shreg_d;
  end

endmodule

// File: tb/tb_clb_bitstream_programmer.sv
// Scoreboard bench: dut_a (NUM_CLB=4) and dut_b (NUM_CLB=1) feed model loader chains; a monitor checks contents, timing and gaps.
module tb_clb_bitstream_programmer;

  localparam int FRAME_W = 37;
  localparam int CHK_TO  = 64;
`ifdef CFG_CHAIN_CHECK_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  localparam logic [36:0] T2 = 37'h1_2345_ABCD;
  localparam logic [36:0] F0 = 37'h0_1234_5678;
  localparam logic [36:0] F1 = 37'h1F_FEDC_BA98;
  localparam logic [36:0] F2 = 37'h0A_A5A5_5A5A;
  localparam logic [36:0] F3 = 37'h15_0F0F_F0F1;
  localparam logic [36:0] G0 = 37'h03_DEAD_BEEF;
  localparam logic [36:0] G1 = 37'h1C_0000_0001;
  localparam logic [36:0] G2 = 37'h10_8000_0000;
  localparam logic [36:0] G3 = 37'h07_CAFE_F00D;

  typedef struct packed {
    logic [3:0][36:0] clb;
    logic [31:0]      len;
    logic             err;
  } sess_t;

  logic clk = 1'b0;
  logic reset;
  logic start_v[2], fvalid_v[2], ready_v[2], chain_done_v[2];
  logic [36:0] fdata_v[2];
  logic bit_v[2], prgm_v[2], en_v[2], chain_in_v[2], busy_v[2], done_v[2], err_v[2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [3:0][36:0] ld[2];
  sess_t exp_sess[2][$];
  int    exp_gap[2][$];
  int    run[2], gap[2], t0[2];
  logic  prev_done[2];

  always #5 clk = ~clk;

  clb_bitstream_programmer_if #(.FRAME_W(FRAME_W)) a_bus ();
  clb_bitstream_programmer_if #(.FRAME_W(FRAME_W)) b_bus ();
  assign a_bus.frame_data  = fdata_v[0];
  assign a_bus.frame_valid = fvalid_v[0];
  assign ready_v[0]        = a_bus.frame_ready;
  assign b_bus.frame_data  = fdata_v[1];
  assign b_bus.frame_valid = fvalid_v[1];
  assign ready_v[1]        = b_bus.frame_ready;

  clb_bitstream_programmer #(.NUM_CLB(4), .FRAME_W(FRAME_W), .CHK_TIMEOUT(CHK_TO)) dut_a (
    .clk(clk), .reset(reset), .start(start_v[0]), .frame(a_bus),
    .bit_out(bit_v[0]), .prgm_b(prgm_v[0]), .clb_prgm_b(en_v[0]), .clb_chain_in(chain_in_v[0]),
    .clb_chain_done(chain_done_v[0]), .busy(busy_v[0]), .done(done_v[0]), .error(err_v[0])
  );

  clb_bitstream_programmer #(.NUM_CLB(1), .FRAME_W(FRAME_W), .CHK_TIMEOUT(CHK_TO)) dut_b (
    .clk(clk), .reset(reset), .start(start_v[1]), .frame(b_bus),
    .bit_out(bit_v[1]), .prgm_b(prgm_v[1]), .clb_prgm_b(en_v[1]), .clb_chain_in(chain_in_v[1]),
    .clb_chain_done(chain_done_v[1]), .busy(busy_v[1]), .done(done_v[1]), .error(err_v[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic sess_t mk(input logic [36:0] c3, input logic [36:0] c2, input logic [36:0] c1,
                               input logic [36:0] c0, input int len, input logic err);
    sess_t s;
    s.clb[3] = c3;
    s.clb[2] = c2;
    s.clb[1] = c1;
    s.clb[0] = c0;
    s.len    = 32'(len);
    s.err    = err;
    return s;
  endfunction

  task automatic pulse_start(input int d);
    start_v[d] = 1'b1;
    @(negedge clk);
    start_v[d] = 1'b0;
  endtask

  // Presents one frame; with stall>0 valid is withheld for that many LOAD cycles.
  task automatic send_frame(input int d, input logic [36:0] f, input int stall);
    int n = 0;
    fdata_v[d]  = f;
    fvalid_v[d] = (stall == 0);
    while (!ready_v[d] && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!ready_v[d]) begin
      checks++;
      errors++;
      $display("FAIL dut%0d frame_ready timeout: got 0, expected 1", d);
      fvalid_v[d] = 1'b0;
      return;
    end
    if (stall > 0) begin
      repeat (stall) @(negedge clk);
      fvalid_v[d] = 1'b1;
    end
    @(negedge clk);
    fvalid_v[d] = 1'b0;
  endtask

  task automatic wait_done(input int d);
    int n = 0;
    while (exp_sess[d].size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (exp_sess[d].size() != 0) begin
      checks++;
      errors++;
      $display("FAIL dut%0d session done timeout: got no done, expected done", d);
      exp_sess[d].delete();
    end
    @(negedge clk);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Monitor: model loader chains, run/gap lengths and end-of-session scoreboard.
  initial begin
    sess_t s;
    int    g;
    for (int d = 0; d < 2; d++) begin
      ld[d] = '0;
      run[d] = 0;
      gap[d] = 0;
      t0[d] = -1;
      prev_done[d] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (en_v[d] === 1'b1) begin
          for (int k = 3; k > 0; k--) ld[d][k] = {ld[d][k-1][0], ld[d][k][36:1]};
          ld[d][0] = {bit_v[d], ld[d][0][36:1]};
        end
        if (reset) begin
          run[d] = 0;
          gap[d] = 0;
          t0[d] = -1;
          prev_done[d] = 1'b0;
        end else begin
          if (ready_v[d] && t0[d] < 0) begin
            t0[d] = cyc;
            check($sformatf("dut%0d prgm_b in session", d), prgm_v[d], 0);
            check($sformatf("dut%0d clb_chain_in in session", d), chain_in_v[d], 1);
            check($sformatf("dut%0d busy in session", d), busy_v[d], 1);
          end
          if (en_v[d]) begin
            if (gap[d] > 0) begin
              if (exp_gap[d].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut%0d unexpected shift gap: got %0d, expected none", d, gap[d]);
              end else begin
                g = exp_gap[d].pop_front();
                check($sformatf("dut%0d shift gap", d), gap[d], g);
              end
            end
            gap[d] = 0;
            run[d]++;
          end else if (run[d] > 0) begin
            check($sformatf("dut%0d shift run length", d), run[d], FRAME_W);
            run[d] = 0;
            gap[d] = 1;
          end else if (gap[d] > 0) begin
            gap[d]++;
          end
          if (prev_done[d]) check($sformatf("dut%0d done pulse width", d), done_v[d], 0);
          prev_done[d] = done_v[d];
          if (done_v[d]) begin
            if (exp_sess[d].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL dut%0d unexpected done: got 1, expected 0", d);
            end else begin
              s = exp_sess[d].pop_front();
              for (int k = 0; k < ((d == 0) ? 4 : 1); k++)
                check($sformatf("dut%0d clb%0d contents", d, k), ld[d][k], s.clb[k]);
              check($sformatf("dut%0d session cycles", d), cyc - t0[d], s.len);
              check($sformatf("dut%0d error at done", d), err_v[d], s.err);
              check($sformatf("dut%0d prgm_b at done", d), prgm_v[d], 1);
              check($sformatf("dut%0d busy at done", d), busy_v[d], 0);
            end
            gap[d] = 0;
            t0[d] = -1;
          end
        end
      end
    end
  end

  initial begin
    logic [36:0] lf;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_v[d] = 1'b1;
      fvalid_v[d] = 1'b0;
      fdata_v[d] = '0;
      chain_done_v[d] = 1'b1;
    end

    // Test 1: reset values, start during reset ignored
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d reset prgm_b", d), prgm_v[d], 1);
      check($sformatf("dut%0d reset clb_prgm_b", d), en_v[d], 0);
      check($sformatf("dut%0d reset frame_ready", d), ready_v[d], 0);
      check($sformatf("dut%0d reset busy", d), busy_v[d], 0);
      check($sformatf("dut%0d reset done", d), done_v[d], 0);
      check($sformatf("dut%0d reset error", d), err_v[d], 0);
      check($sformatf("dut%0d reset bit_out", d), bit_v[d], 0);
      check($sformatf("dut%0d reset clb_chain_in", d), chain_in_v[d], 0);
    end
    reset = 1'b0;
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) check($sformatf("dut%0d busy after reset", d), busy_v[d], 0);

    // Test 2: NUM_CLB=1, frame valid already before start
    fdata_v[1] = T2;
    fvalid_v[1] = 1'b1;
    @(negedge clk);
    check("dut1 no shift while idle", en_v[1], 0);
    exp_sess[1].push_back(mk('0, '0, '0, T2, FRAME_W + 1 + EXTRA, 1'b0));
    pulse_start(1);
    send_frame(1, T2, 0);
    wait_done(1);
    lf = ld[1][0];
    check("t2 lut", lf[15:0], 16'hABCD);
    check("t2 switch", lf[16], 1'b1);
    check("t2 x1", lf[21:17], 5'h02);
    check("t2 x2", lf[26:22], 5'h0D);
    check("t2 x3", lf[31:27], 5'h04);
    check("t2 x4", lf[36:32], 5'h01);

    // Test 3: NUM_CLB=4 back-to-back, start while busy ignored
    exp_sess[0].push_back(mk(F0, F1, F2, F3, 4 * 38 + EXTRA, 1'b0));
    repeat (3) exp_gap[0].push_back(1);
    pulse_start(0);
    send_frame(0, F0, 0);
    send_frame(0, F1, 0);
    pulse_start(0);
    send_frame(0, F2, 0);
    send_frame(0, F3, 0);
    wait_done(0);

    // Test 4: 10-cycle stall before frame 2
    exp_sess[0].push_back(mk(F0, F1, F2, F3, 4 * 38 + 10 + EXTRA, 1'b0));
    exp_gap[0].push_back(1);
    exp_gap[0].push_back(11);
    exp_gap[0].push_back(1);
    pulse_start(0);
    send_frame(0, F0, 0);
    send_frame(0, F1, 0);
    send_frame(0, F2, 10);
    send_frame(0, F3, 0);
    wait_done(0);

    // Test 5: reset on the 20th shift cycle of frame 2, then a full new session
    exp_gap[0].push_back(1);
    exp_gap[0].push_back(1);
    pulse_start(0);
    send_frame(0, F0, 0);
    send_frame(0, F1, 0);
    send_frame(0, F2, 0);
    repeat (19) @(negedge clk);
    check("t5 shifting before reset", en_v[0], 1);
    reset = 1'b1;
    @(negedge clk);
    check("t5 prgm_b after reset", prgm_v[0], 1);
    check("t5 busy after reset", busy_v[0], 0);
    check("t5 clb_prgm_b after reset", en_v[0], 0);
    check("t5 frame_ready after reset", ready_v[0], 0);
    check("t5 clb_chain_in after reset", chain_in_v[0], 0);
    @(negedge clk);
    reset = 1'b0;
    check("t5 abandoned gaps consumed", exp_gap[0].size(), 0);
    exp_sess[0].push_back(mk(G0, G1, G2, G3, 4 * 38 + EXTRA, 1'b0));
    repeat (3) exp_gap[0].push_back(1);
    pulse_start(0);
    send_frame(0, G0, 0);
    send_frame(0, G1, 0);
    send_frame(0, G2, 0);
    send_frame(0, G3, 0);
    wait_done(0);

`ifdef CFG_CHAIN_CHECK_EN
    // Test 6: chain check timeout, then success clears error
    chain_done_v[1] = 1'b0;
    exp_sess[1].push_back(mk('0, '0, '0, G3, FRAME_W + 1 + CHK_TO, 1'b1));
    pulse_start(1);
    send_frame(1, G3, 0);
    wait_done(1);
    check("t6 error sticky", err_v[1], 1);
    chain_done_v[1] = 1'b1;
    exp_sess[1].push_back(mk('0, '0, '0, G0, FRAME_W + 2, 1'b0));
    pulse_start(1);
    check("t6 error cleared by start", err_v[1], 0);
    send_frame(1, G0, 0);
    wait_done(1);
`endif

    repeat (3) @(negedge clk);
    check("dut0 scoreboard drained", exp_sess[0].size() + exp_gap[0].size(), 0);
    check("dut1 scoreboard drained", exp_sess[1].size() + exp_gap[1].size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
